// File: rtl/gpu_launch_ctrl.sv
// Kernel launch sequencer: enable write, programmable gap, start write, wait for the
// completion interrupt (optionally bounded by a timeout), clear write, then a done pulse.
module gpu_launch_ctrl #(
    parameter int unsigned GAP_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        launch_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        conf_req_o,
    output logic        conf_we_o,
    output logic [3:0]  conf_be_o,
    output logic [31:0] conf_addr_o,
    output logic [31:0] conf_wdata_o,
    input  logic        conf_gnt_i,
    input  logic        conf_rvalid_i,
    input  logic        interrupt_i
);

    localparam logic [31:0] ADDR_EN    = 32'h0;
    localparam logic [31:0] ADDR_START = 32'h4;
    localparam logic [31:0] ADDR_CLR   = 32'h8;
    localparam logic [31:0] WDATA_ONE  = 32'h1;
    localparam logic [31:0] GAP_LD     = GAP_CYCLES;
    localparam logic [31:0] TO_LD      = TIMEOUT_CYCLES;

    typedef enum logic [3:0] {
        IDLE, WR_EN, RSP_EN, GAP, WR_START, RSP_START, WAIT_IRQ, WR_CLR, RSP_CLR, DONE
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_cnt;

    // Address/data are only non-zero while the request is up, so they are
    // always loaded and cleared together with r_req.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (launch_i) begin
                        r_state   <= WR_EN;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                        r_req     <= 1'b1;
                        r_addr    <= ADDR_EN;
                        r_wdata   <= WDATA_ONE;
                    end
                end
                WR_EN: begin
                    if (conf_gnt_i) begin
                        r_state <= RSP_EN;
                        r_req   <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end
                end
                RSP_EN: begin
                    if (conf_rvalid_i) begin
                        if (GAP_CYCLES == 0) begin
                            r_state <= WR_START;
                            r_req   <= 1'b1;
                            r_addr  <= ADDR_START;
                            r_wdata <= WDATA_ONE;
                        end else begin
                            r_state <= GAP;
                            r_cnt   <= GAP_LD;
                        end
                    end
                end
                GAP: begin
                    if (r_cnt <= 32'd1) begin
                        r_state <= WR_START;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_addr  <= ADDR_START;
                        r_wdata <= WDATA_ONE;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                WR_START: begin
                    if (conf_gnt_i) begin
                        r_state <= RSP_START;
                        r_req   <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end
                end
                RSP_START: begin
                    if (conf_rvalid_i) begin
                        r_state <= WAIT_IRQ;
                        r_cnt   <= TO_LD;
                    end
                end
                WAIT_IRQ: begin
                    // The interrupt is checked first so it wins over a timeout expiring in the same cycle.
                    if (interrupt_i) begin
                        r_state <= WR_CLR;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_addr  <= ADDR_CLR;
                        r_wdata <= WDATA_ONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_cnt <= 32'd1)) begin
                        r_state   <= WR_CLR;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                        r_req     <= 1'b1;
                        r_addr    <= ADDR_CLR;
                        r_wdata   <= WDATA_ONE;
                    end else if (r_cnt != 32'd0) begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                WR_CLR: begin
                    if (conf_gnt_i) begin
                        r_state <= RSP_CLR;
                        r_req   <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end
                end
                RSP_CLR: begin
                    if (conf_rvalid_i) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;
    assign conf_req_o   = r_req;
    assign conf_we_o    = 1'b1;
    assign conf_be_o    = 4'b1111;
    assign conf_addr_o  = r_addr;
    assign conf_wdata_o = r_wdata;

endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// Bench for gpu_launch_ctrl: three instances (long gap, short gap with timeout, zero gap),
// one selected at a time, driven by a randomized OBI responder and interrupt source.
module tb_gpu_launch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, launch, gnt, rvalid, irq;
    logic [1:0]  sel;
    logic        busy_v [3], done_v [3], to_v [3], req_v [3], we_v [3];
    logic [3:0]  be_v   [3];
    logic [31:0] addr_v [3], wd_v [3];

    int tests = 0;
    int fails = 0;
    logic [31:0] txq[$];

    gpu_launch_ctrl #(.GAP_CYCLES(50), .TIMEOUT_CYCLES(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .launch_i(launch && sel == 2'd0),
        .busy_o(busy_v[0]), .done_o(done_v[0]), .timeout_o(to_v[0]),
        .conf_req_o(req_v[0]), .conf_we_o(we_v[0]), .conf_be_o(be_v[0]),
        .conf_addr_o(addr_v[0]), .conf_wdata_o(wd_v[0]),
        .conf_gnt_i(gnt && sel == 2'd0), .conf_rvalid_i(rvalid && sel == 2'd0),
        .interrupt_i(irq && sel == 2'd0));

    gpu_launch_ctrl #(.GAP_CYCLES(3), .TIMEOUT_CYCLES(20)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .launch_i(launch && sel == 2'd1),
        .busy_o(busy_v[1]), .done_o(done_v[1]), .timeout_o(to_v[1]),
        .conf_req_o(req_v[1]), .conf_we_o(we_v[1]), .conf_be_o(be_v[1]),
        .conf_addr_o(addr_v[1]), .conf_wdata_o(wd_v[1]),
        .conf_gnt_i(gnt && sel == 2'd1), .conf_rvalid_i(rvalid && sel == 2'd1),
        .interrupt_i(irq && sel == 2'd1));

    gpu_launch_ctrl #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .launch_i(launch && sel == 2'd2),
        .busy_o(busy_v[2]), .done_o(done_v[2]), .timeout_o(to_v[2]),
        .conf_req_o(req_v[2]), .conf_we_o(we_v[2]), .conf_be_o(be_v[2]),
        .conf_addr_o(addr_v[2]), .conf_wdata_o(wd_v[2]),
        .conf_gnt_i(gnt && sel == 2'd2), .conf_rvalid_i(rvalid && sel == 2'd2),
        .interrupt_i(irq && sel == 2'd2));

    logic        busy_m, done_m, to_m, req_m, we_m;
    logic [3:0]  be_m;
    logic [31:0] addr_m, wd_m;
    assign busy_m = busy_v[sel];
    assign done_m = done_v[sel];
    assign to_m   = to_v[sel];
    assign req_m  = req_v[sel];
    assign we_m   = we_v[sel];
    assign be_m   = be_v[sel];
    assign addr_m = addr_v[sel];
    assign wd_m   = wd_v[sel];

    // Every accepted request (req and gnt both high at the edge) is one transaction.
    always @(posedge clk) if (req_m === 1'b1 && gnt === 1'b1) txq.push_back(addr_m);

    function automatic int gap_of(input logic [1:0] s);
        case (s)
            2'd0:    return 50;
            2'd1:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int to_of(input logic [1:0] s);
        return (s == 2'd1) ? 20 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int maxc, output int waited, input logic noise, input logic irq_hold);
        waited = 0;
        while (req_m !== 1'b1 && waited < maxc) begin
            launch = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            irq    = irq_hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            step();
            waited++;
        end
        launch = 1'b0;
        irq    = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic [31:0] exp_addr, input int gdly,
                          input int rdly, input logic noise);
        logic stable_ok, quiet_ok;
        stable_ok = 1'b1;
        quiet_ok  = 1'b1;
        chk({tag, "_req"},   {31'd0, req_m}, 32'd1);
        chk({tag, "_addr"},  addr_m, exp_addr);
        chk({tag, "_wdata"}, wd_m, 32'h1);
        chk({tag, "_we_be"}, {27'd0, we_m, be_m}, 32'h1f);
        for (int i = 0; i < gdly; i++) begin
            gnt = 1'b0;
            if (noise) begin
                launch = 1'($urandom_range(0, 1));
                irq    = 1'($urandom_range(0, 1));
            end
            step();
            if (req_m !== 1'b1 || addr_m !== exp_addr || wd_m !== 32'h1) stable_ok = 1'b0;
        end
        chk({tag, "_hold"}, {31'd0, stable_ok}, 32'd1);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk({tag, "_drop"}, {31'd0, req_m}, 32'd0);
        chk({tag, "_idle_bus"}, addr_m | wd_m, 32'd0);
        for (int i = 0; i < rdly; i++) begin
            step();
            if (req_m !== 1'b0 || busy_m !== 1'b1) quiet_ok = 1'b0;
        end
        chk({tag, "_rsp_wait"}, {31'd0, quiet_ok}, 32'd1);
        rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        launch = 1'b0;
        irq    = 1'b0;
    endtask

    // One full launch; gdly < 0 picks a random grant delay; irq_after = quiet cycles in
    // WAIT_IRQ before the interrupt is raised.
    task automatic run_seq(input logic [1:0] s, input int gdly, input int irq_after,
                           input logic noise, input logic irq_gap);
        int   w, g;
        int   t, exp_wait;
        logic exp_to;
        logic [31:0] exp_addrs[$];
        sel = s;
        exp_addrs = '{32'h0, 32'h4, 32'h8};
        t = to_of(s);
        exp_to   = (t > 0) && (irq_after >= t);
        exp_wait = exp_to ? t : irq_after + 1;
        txq.delete();
        launch = 1'b1;
        step();
        launch = 1'b0;
        chk("launch_busy", {31'd0, busy_m}, 32'd1);
        chk("launch_clears_timeout", {31'd0, to_m}, 32'd0);
        g = (gdly < 0) ? int'($urandom_range(0, 3)) : gdly;
        do_txn("en", 32'h0, g, int'($urandom_range(0, 3)), noise);
        wait_req(200, w, noise, irq_gap);
        chk("gap_len", w, gap_of(s));
        g = (gdly < 0) ? int'($urandom_range(0, 3)) : gdly;
        do_txn("start", 32'h4, g, int'($urandom_range(0, 3)), noise);
        w = 0;
        while (req_m !== 1'b1 && w < 300) begin
            irq    = (w >= irq_after);
            launch = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            w++;
        end
        irq    = 1'b0;
        launch = 1'b0;
        chk("irq_wait", w, exp_wait);
        chk("timeout_flag", {31'd0, to_m}, {31'd0, exp_to});
        g = (gdly < 0) ? int'($urandom_range(0, 3)) : gdly;
        do_txn("clr", 32'h8, g, int'($urandom_range(0, 3)), noise);
        chk("done_pulse", {31'd0, done_m}, 32'd1);
        chk("done_busy", {31'd0, busy_m}, 32'd1);
        step();
        chk("done_end", {31'd0, done_m}, 32'd0);
        chk("idle_busy", {31'd0, busy_m}, 32'd0);
        chk("timeout_sticky", {31'd0, to_m}, {31'd0, exp_to});
        chk("txn_count", txq.size(), exp_addrs.size());
        for (int i = 0; i < exp_addrs.size() && i < txq.size(); i++)
            chk("txn_addr", txq[i], exp_addrs[i]);
    endtask

    initial begin
        int w;
        sel = 2'd0; launch = 1'b0; gnt = 1'b0; rvalid = 1'b0; irq = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_ctrl", {28'd0, busy_m, done_m, to_m, req_m}, 32'd0);
            chk("rst_bus", addr_m | wd_m, 32'd0);
            chk("rst_we_be", {27'd0, we_m, be_m}, 32'h1f);
        end
        sel = 2'd0;
        step();
        step();
        rst_n = 1'b1;
        step();

        run_seq(2'd0, 0, 100, 1'b0, 1'b0);
        run_seq(2'd0, 7, int'($urandom_range(0, 20)), 1'b0, 1'b0);
        run_seq(2'd0, -1, int'($urandom_range(0, 20)), 1'b1, 1'b1);
        run_seq(2'd1, -1, 40, 1'b0, 1'b0);
        run_seq(2'd1, -1, 19, 1'b0, 1'b0);
        run_seq(2'd1, -1, 20, 1'b1, 1'b0);
        run_seq(2'd2, 0, int'($urandom_range(0, 10)), 1'b0, 1'b0);

        // Reset while the start write waits for its grant.
        sel = 2'd0;
        launch = 1'b1;
        step();
        launch = 1'b0;
        do_txn("rst_en", 32'h0, 0, 0, 1'b0);
        wait_req(200, w, 1'b0, 1'b0);
        chk("rst_gap_len", w, 50);
        step();
        step();
        chk("rst_pending_req", {31'd0, req_m}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, req_m}, 32'd0);
        chk("rst_async_busy", {31'd0, busy_m}, 32'd0);
        chk("rst_async_bus", addr_m | wd_m, 32'd0);
        #2 rst_n = 1'b1;
        step();
        rvalid = 1'b1;
        irq    = 1'b1;
        step();
        rvalid = 1'b0;
        irq    = 1'b0;
        step();
        chk("idle_ignores_rsp", {30'd0, busy_m, req_m}, 32'd0);
        run_seq(2'd0, -1, int'($urandom_range(0, 10)), 1'b0, 1'b0);

        for (int k = 0; k < 6; k++)
            run_seq(2'($urandom_range(0, 2)), -1, int'($urandom_range(0, 30)), 1'b1,
                    1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
